prog_mod_counter: RTL and testbench

Runtime-programmable modulo counter with up/down direction, synchronous clear and load, and a terminal-count output for cascading. The modulus is a register reloaded at run time, so one instance covers any modulus from 1 to 2^W, including non-powers of 2. It sits wherever the design needs divide-by-N timing, baud/tick generation or multi-digit chained counters (tc of one stage drives en of the next).

---
 rtl/prog_mod_counter.sv | 90 +++++++++
 tb/tb_prog_mod_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulo counter: up/down, clear, load with range check,
// combinational terminal count for lockstep cascading.
module prog_mod_counter #(
   parameter int unsigned W           = 8,
   parameter int unsigned MOD_DEFAULT = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         mod_wr,
   input  logic [W-1:0] mod_val,
   output logic [W-1:0] count,
   output logic [W-1:0] mod_cur,
   output logic         tc,
   output logic         wrap,
   output logic         load_err
);

   localparam int unsigned WE = W + 1;

   logic [W-1:0]  r_count;
   logic [W-1:0]  r_mod;
   logic          r_wrap;
   logic          r_load_err;

   logic [WE-1:0] w_m1;
   logic [WE-1:0] w_cnt_ext;
   logic          w_at_top;
   logic          w_at_zero;
   logic          w_load_ok;
   logic          w_tc;
   logic [W-1:0]  w_count_nxt;
   logic          w_load_err_nxt;

   // M-1 kept one bit wider so modulus 0 (= 2^W) yields all-ones without truncation
   assign w_m1      = (r_mod == '0) ? {1'b0, {W{1'b1}}} : (WE'(r_mod) - WE'(1));
   assign w_cnt_ext = WE'(r_count);
   assign w_at_top  = (w_cnt_ext >= w_m1);
   assign w_at_zero = (r_count == '0);
   assign w_load_ok = (WE'(load_val) <= w_m1);
   assign w_tc      = en & ~clr & ~load & (up ? w_at_top : w_at_zero);

   // Next-count selection: clr > load > en > hold
   always_comb begin
      w_count_nxt    = r_count;
      w_load_err_nxt = 1'b0;
      if (clr) begin
         w_count_nxt = '0;
      end else if (load) begin
         w_count_nxt    = w_load_ok ? load_val : '0;
         w_load_err_nxt = ~w_load_ok;
      end else if (en) begin
         if (up) begin
            w_count_nxt = w_at_top ? '0 : (r_count + W'(1));
         end else if (w_at_zero || (w_cnt_ext > w_m1)) begin
            // a count left above a shrunken modulus lands on the new top, not a wrap
            w_count_nxt = W'(w_m1);
         end else begin
            w_count_nxt = r_count - W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= '0;
         r_mod      <= W'(MOD_DEFAULT);
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         r_wrap     <= w_tc;
         r_load_err <= w_load_err_nxt;
         if (mod_wr) begin
            r_mod <= mod_val;
         end
      end
   end

   assign count    = r_count;
   assign mod_cur  = r_mod;
   assign tc       = w_tc;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed bench for prog_mod_counter: single instance plus a two-digit decimal cascade.
module tb_prog_mod_counter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst, en, up, clr, load, mod_wr;
   logic [W-1:0] load_val, mod_val;
   logic [W-1:0] count, mod_cur;
   logic         tc, wrap, load_err;

   logic         c_rst;
   logic         c_en;
   logic [W-1:0] lo_count, hi_count, lo_mod, hi_mod;
   logic         lo_tc, hi_tc, lo_wrap, hi_wrap, lo_lerr, hi_lerr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   prog_mod_counter #(.W(W), .MOD_DEFAULT(10)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val),
      .count(count), .mod_cur(mod_cur), .tc(tc), .wrap(wrap), .load_err(load_err)
   );

   prog_mod_counter #(.W(W), .MOD_DEFAULT(10)) u_lo (
      .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .clr(1'b0), .load(1'b0),
      .load_val(8'd0), .mod_wr(1'b0), .mod_val(8'd0),
      .count(lo_count), .mod_cur(lo_mod), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_lerr)
   );

   prog_mod_counter #(.W(W), .MOD_DEFAULT(10)) u_hi (
      .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
      .load_val(8'd0), .mod_wr(1'b0), .mod_val(8'd0),
      .count(hi_count), .mod_cur(hi_mod), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_lerr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; mod_wr = 1'b0;
      load_val = '0; mod_val = '0;
      c_rst = 1'b1; c_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_mod", mod_cur, 10);
      chk("rst_wrap", wrap, 0);
      chk("rst_lerr", load_err, 0);
      chk("rst_tc", tc, 0);

      // decade up-count, 25 steps
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 25; i++) begin
         #1;
         chk("up_count", count, i % 10);
         chk("up_tc", tc, (i % 10) == 9);
         chk("up_wrap", wrap, (i > 0) && ((i % 10) == 0));
         tick();
      end

      // shrink modulus below current count
      en = 1'b0; load = 1'b1; load_val = 8'd7;
      tick();
      load = 1'b0; mod_wr = 1'b1; mod_val = 8'd5;
      #1;
      chk("ld7_count", count, 7);
      chk("ld7_lerr", load_err, 0);
      tick();
      mod_wr = 1'b0;
      #1;
      chk("shrink_mod", mod_cur, 5);
      chk("shrink_hold", count, 7);
      tick();
      chk("shrink_hold2", count, 7);
      en = 1'b1;
      #1;
      chk("shrink_tc", tc, 1);
      tick();
      en = 1'b0;
      #1;
      chk("shrink_wrapcnt", count, 0);
      chk("shrink_wrap", wrap, 1);

      // load range check at M=10
      mod_wr = 1'b1; mod_val = 8'd10;
      tick();
      mod_wr = 1'b0; load = 1'b1; load_val = 8'd9;
      tick();
      chk("ld9_count", count, 9);
      chk("ld9_lerr", load_err, 0);
      load_val = 8'd12;
      tick();
      chk("ld12_count", count, 0);
      chk("ld12_lerr", load_err, 1);
      load_val = 8'd9;
      tick();
      chk("ld9b_count", count, 9);
      chk("ld9b_lerr", load_err, 0);
      clr = 1'b1; en = 1'b1; load_val = 8'd3;
      #1;
      chk("clr_tc", tc, 0);
      tick();
      clr = 1'b0; load = 1'b0; en = 1'b0;
      #1;
      chk("clr_count", count, 0);

      // modulus 2^W, down-count from 0
      mod_wr = 1'b1; mod_val = 8'd0;
      tick();
      mod_wr = 1'b0;
      #1;
      chk("m256_mod", mod_cur, 0);
      en = 1'b1; up = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("dn_count", count, (i == 0) ? 0 : 256 - i);
         chk("dn_tc", tc, i == 0);
         chk("dn_wrap", wrap, i == 1);
         tick();
      end
      en = 1'b0; load = 1'b1; load_val = 8'd255; up = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      #1;
      chk("m256_top", count, 255);
      chk("m256_tc", tc, 1);
      tick();
      chk("m256_wrap", count, 0);

      // down step from above a shrunken modulus goes to M-1 without tc
      en = 1'b0; load = 1'b1; load_val = 8'd200;
      tick();
      load = 1'b0; mod_wr = 1'b1; mod_val = 8'd10;
      tick();
      mod_wr = 1'b0; en = 1'b1; up = 1'b0;
      #1;
      chk("dnshr_pre", count, 200);
      chk("dnshr_tc", tc, 0);
      tick();
      chk("dnshr_count", count, 9);
      chk("dnshr_wrap", wrap, 0);

      // M == 1 in both directions
      en = 1'b0; clr = 1'b1; mod_wr = 1'b1; mod_val = 8'd1;
      tick();
      clr = 1'b0; mod_wr = 1'b0;
      #1;
      chk("m1_mod", mod_cur, 1);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up = i[0];
         #1;
         chk("m1_count", count, 0);
         chk("m1_tc", tc, 1);
         chk("m1_wrap", wrap, i > 0);
         tick();
      end

      // reset mid-activity overrides every other input
      rst = 1'b1; load = 1'b1; load_val = 8'd0; mod_wr = 1'b1; mod_val = 8'd33;
      tick();
      rst = 1'b0; load = 1'b0; mod_wr = 1'b0; en = 1'b0;
      #1;
      chk("rst2_count", count, 0);
      chk("rst2_mod", mod_cur, 10);
      chk("rst2_wrap", wrap, 0);
      chk("rst2_lerr", load_err, 0);

      // decimal cascade: 120 cycles
      c_rst = 1'b0;
      for (int c = 0; c < 120; c++) begin
         #1;
         chk("casc_val", 32'(hi_count) * 10 + 32'(lo_count), c % 100);
         tick();
      end

      // cascade reset at cycle 57
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0;
      for (int c = 0; c < 57; c++) tick();
      #1;
      chk("casc_57", 32'(hi_count) * 10 + 32'(lo_count), 57);
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0;
      #1;
      chk("casc_rst_lo", lo_count, 0);
      chk("casc_rst_hi", hi_count, 0);
      tick();
      chk("casc_after", 32'(hi_count) * 10 + 32'(lo_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
